// File: rtl/myreg_host_arb.sv
// -----------------------------------------------------------------------------
// myreg_host_arb
// Round-robin arbiter that lets NumHosts req/gnt/rvalid bus hosts share the
// single device port of the register block. The arbiter forwards one
// transaction at a time and returns the response to the host that owns it.
// A watchdog returns an error response when the device never answers.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   host_req_i          per-host request
//   host_gnt_o          per-host grant, combinational, one-hot or zero
//   host_addr_i         packed addresses, host k at [k*AddrWidth +: AddrWidth]
//   host_we_i           per-host write enable
//   host_be_i           packed byte enables, host k at [k*4 +: 4]
//   host_wdata_i        packed write data, host k at [k*32 +: 32]
//   host_rvalid_o       per-host response valid, one-hot or zero
//   host_err_o          per-host error flag, qualified by host_rvalid_o
//   host_rdata_o        shared response data, zero when no response
//   device_req_o        request to the register block
//   device_addr_o/we_o/be_o/wdata_o   fields of the granted host
//   device_rvalid_i     device response valid
//   device_rdata_i      device read data
//   busy_o              high in the grant cycle and while a response is due
// -----------------------------------------------------------------------------
module myreg_host_arb #(
    parameter int AddrWidth     = 32,
    parameter int NumHosts      = 2,
    parameter int TimeoutCycles = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumHosts-1:0]           host_req_i,
    output logic [NumHosts-1:0]           host_gnt_o,
    input  logic [NumHosts*AddrWidth-1:0] host_addr_i,
    input  logic [NumHosts-1:0]           host_we_i,
    input  logic [NumHosts*4-1:0]         host_be_i,
    input  logic [NumHosts*32-1:0]        host_wdata_i,
    output logic [NumHosts-1:0]           host_rvalid_o,
    output logic [NumHosts-1:0]           host_err_o,
    output logic [31:0]                   host_rdata_o,
    output logic                          device_req_o,
    output logic [AddrWidth-1:0]          device_addr_o,
    output logic                          device_we_o,
    output logic [3:0]                    device_be_o,
    output logic [31:0]                   device_wdata_o,
    input  logic                          device_rvalid_i,
    input  logic [31:0]                   device_rdata_i,
    output logic                          busy_o
);

    localparam int PtrW = $clog2(NumHosts);
    localparam int CntW = $clog2(TimeoutCycles);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e          r_state;
    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] r_owner;
    logic [CntW-1:0] r_cnt;

    logic [PtrW-1:0] w_winner;
    logic [PtrW-1:0] w_ptr_nxt;
    logic            w_grant;
    logic            w_timeout;
    logic            w_resp;

    // Round-robin pick: scan downward so the requester closest to the
    // pointer is written last and therefore wins.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_winner = '0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            if (host_req_i[(int'(r_ptr) + i) % NumHosts]) begin
                w_winner = PtrW'((int'(r_ptr) + i) % NumHosts);
            end
        end
    end

    assign w_ptr_nxt = (w_winner == PtrW'(NumHosts - 1)) ? '0 : w_winner + 1'b1;

    // The grant is combinational from the requests, so it is also gated by
    // rst_ni: a grant shown while in reset would be lost.
    assign w_grant   = rst_ni && (r_state == ST_IDLE) && (|host_req_i);
    assign w_timeout = (r_state == ST_WAIT) && (r_cnt == CntW'(TimeoutCycles - 1));
    // A device answer in the timeout cycle still counts as a normal response.
    assign w_resp    = (r_state == ST_WAIT) && (device_rvalid_i || w_timeout);
    assign busy_o    = w_grant || (r_state == ST_WAIT);

    always_comb begin
        host_gnt_o     = '0;
        device_req_o   = 1'b0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        host_rvalid_o  = '0;
        host_err_o     = '0;
        host_rdata_o   = '0;
        if (w_grant) begin
            host_gnt_o[w_winner] = 1'b1;
            device_req_o         = 1'b1;
            device_addr_o        = host_addr_i[int'(w_winner)*AddrWidth +: AddrWidth];
            device_we_o          = host_we_i[w_winner];
            device_be_o          = host_be_i[int'(w_winner)*4 +: 4];
            device_wdata_o       = host_wdata_i[int'(w_winner)*32 +: 32];
        end
        if (w_resp) begin
            host_rvalid_o[r_owner] = 1'b1;
            host_err_o[r_owner]    = !device_rvalid_i;
            host_rdata_o           = device_rvalid_i ? device_rdata_i : 32'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant) begin
                r_owner <= w_winner;
                r_ptr   <= w_ptr_nxt;
                r_cnt   <= '0;
                r_state <= ST_WAIT;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_resp) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_myreg_host_arb.sv
// -----------------------------------------------------------------------------
// tb_myreg_host_arb
// Self-checking bench for myreg_host_arb: directed scenarios followed by a
// randomized run compared against a transaction-level round-robin model.
// -----------------------------------------------------------------------------
module tb_myreg_host_arb;

    localparam int AW = 32;
    localparam int NH = 2;
    localparam int TO = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NH-1:0]     host_req_i;
    logic [NH-1:0]     host_gnt_o;
    logic [NH*AW-1:0]  host_addr_i;
    logic [NH-1:0]     host_we_i;
    logic [NH*4-1:0]   host_be_i;
    logic [NH*32-1:0]  host_wdata_i;
    logic [NH-1:0]     host_rvalid_o;
    logic [NH-1:0]     host_err_o;
    logic [31:0]       host_rdata_o;
    logic              device_req_o;
    logic [AW-1:0]     device_addr_o;
    logic              device_we_o;
    logic [3:0]        device_be_o;
    logic [31:0]       device_wdata_o;
    logic              device_rvalid_i;
    logic [31:0]       device_rdata_i;
    logic              busy_o;

    logic [AW-1:0] h_addr  [NH];
    logic          h_we    [NH];
    logic [3:0]    h_be    [NH];
    logic [31:0]   h_wdata [NH];

    int total  = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < NH; k++) begin
            host_addr_i[k*AW +: AW]  = h_addr[k];
            host_we_i[k]             = h_we[k];
            host_be_i[k*4 +: 4]      = h_be[k];
            host_wdata_i[k*32 +: 32] = h_wdata[k];
        end
    end

    myreg_host_arb #(
        .AddrWidth    (AW),
        .NumHosts     (NH),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .host_req_i     (host_req_i),
        .host_gnt_o     (host_gnt_o),
        .host_addr_i    (host_addr_i),
        .host_we_i      (host_we_i),
        .host_be_i      (host_be_i),
        .host_wdata_i   (host_wdata_i),
        .host_rvalid_o  (host_rvalid_o),
        .host_err_o     (host_err_o),
        .host_rdata_o   (host_rdata_o),
        .device_req_o   (device_req_o),
        .device_addr_o  (device_addr_o),
        .device_we_o    (device_we_o),
        .device_be_o    (device_be_o),
        .device_wdata_o (device_wdata_o),
        .device_rvalid_i(device_rvalid_i),
        .device_rdata_i (device_rdata_i),
        .busy_o         (busy_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one more unit later, well clear of either edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        host_req_i      = '0;
        device_rvalid_i = 1'b0;
        device_rdata_i  = '0;
        for (int k = 0; k < NH; k++) begin
            h_addr[k]  = '0;
            h_we[k]    = 1'b0;
            h_be[k]    = '0;
            h_wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        host_req_i      = 2'b11;
        device_rvalid_i = 1'b1;
        device_rdata_i  = 32'h1234_5678;
        #3;
        total++;
        if ({host_gnt_o, host_rvalid_o, host_err_o, device_req_o, busy_o} !== '0)
            $display("FAIL reset_ctrl got gnt=%b rv=%b err=%b req=%b busy=%b exp all 0",
                     host_gnt_o, host_rvalid_o, host_err_o, device_req_o, busy_o);
        else passed++;
        total++;
        if ({host_rdata_o, device_addr_o, device_be_o, device_wdata_o, device_we_o} !== '0)
            $display("FAIL reset_data got rdata=%h addr=%h be=%b wdata=%h we=%b exp all 0",
                     host_rdata_o, device_addr_o, device_be_o, device_wdata_o, device_we_o);
        else passed++;
        do_reset();
        #1;
        total++;
        if ({host_gnt_o, host_rvalid_o, device_req_o, busy_o, host_rdata_o} !== '0)
            $display("FAIL after_reset got gnt=%b rv=%b req=%b busy=%b rdata=%h exp all 0",
                     host_gnt_o, host_rvalid_o, device_req_o, busy_o, host_rdata_o);
        else passed++;
    endtask

    task automatic test_single();
        do_reset();
        h_addr[0] = 32'h4; h_we[0] = 1'b0; h_be[0] = 4'hF;
        host_req_i = 2'b01;
        #1;
        total++;
        if (host_gnt_o !== 2'b01 || device_req_o !== 1'b1 || device_addr_o !== 32'h4 ||
            device_we_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL single_grant got gnt=%b req=%b addr=%h we=%b busy=%b exp 01 1 4 0 1",
                     host_gnt_o, device_req_o, device_addr_o, device_we_o, busy_o);
        else passed++;
        next_cycle();
        host_req_i      = 2'b00;
        device_rvalid_i = 1'b1;
        device_rdata_i  = 32'hA5A5_0001;
        #1;
        total++;
        if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b00 || host_rdata_o !== 32'hA5A5_0001 ||
            host_gnt_o !== 2'b00 || device_req_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL single_resp got rv=%b err=%b rdata=%h gnt=%b req=%b busy=%b exp 01 00 a5a50001 00 0 1",
                     host_rvalid_o, host_err_o, host_rdata_o, host_gnt_o, device_req_o, busy_o);
        else passed++;
        next_cycle();
        device_rvalid_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0 || host_rvalid_o !== 2'b00)
            $display("FAIL single_idle got busy=%b rv=%b exp 0 00", busy_o, host_rvalid_o);
        else passed++;
    endtask

    task automatic test_fairness();
        logic [NH-1:0] exp_one;
        do_reset();
        h_addr[0] = 32'h100; h_addr[1] = 32'h200;
        host_req_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_one = (t % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total++;
            if (host_gnt_o !== exp_one || device_addr_o !== ((t % 2 == 0) ? 32'h100 : 32'h200))
                $display("FAIL fair_grant%0d got gnt=%b addr=%h exp gnt=%b", t, host_gnt_o,
                         device_addr_o, exp_one);
            else passed++;
            next_cycle();
            device_rvalid_i = 1'b1;
            device_rdata_i  = 32'hC0DE_0000 + 32'(t);
            #1;
            total++;
            if (host_rvalid_o !== exp_one || host_rdata_o !== 32'hC0DE_0000 + 32'(t) || host_gnt_o !== 2'b00)
                $display("FAIL fair_resp%0d got rv=%b rdata=%h gnt=%b exp rv=%b", t, host_rvalid_o,
                         host_rdata_o, host_gnt_o, exp_one);
            else passed++;
            next_cycle();
            device_rvalid_i = 1'b0;
        end
        host_req_i = 2'b00;
    endtask

    task automatic test_write_be();
        do_reset();
        h_addr[0] = 32'hFFFF_FFF0; h_we[0] = 1'b0; h_be[0] = 4'hF; h_wdata[0] = 32'h1111_1111;
        h_addr[1] = 32'h0;         h_we[1] = 1'b1; h_be[1] = 4'b0011; h_wdata[1] = 32'hDEAD_BEEF;
        host_req_i = 2'b10;
        #1;
        total++;
        if (host_gnt_o !== 2'b10 || device_we_o !== 1'b1 || device_be_o !== 4'b0011 ||
            device_wdata_o !== 32'hDEAD_BEEF || device_addr_o !== 32'h0)
            $display("FAIL write_fwd got gnt=%b we=%b be=%b wdata=%h addr=%h exp 10 1 0011 deadbeef 0",
                     host_gnt_o, device_we_o, device_be_o, device_wdata_o, device_addr_o);
        else passed++;
        next_cycle();
        host_req_i      = 2'b00;
        device_rvalid_i = 1'b1;
        device_rdata_i  = 32'h0;
        #1;
        total++;
        if (host_rvalid_o !== 2'b10 || host_err_o !== 2'b00)
            $display("FAIL write_resp got rv=%b err=%b exp 10 00", host_rvalid_o, host_err_o);
        else passed++;
        next_cycle();
        device_rvalid_i = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        h_addr[0] = 32'h8;
        host_req_i = 2'b01;
        #1;
        total++;
        if (host_gnt_o !== 2'b01)
            $display("FAIL to_grant got gnt=%b exp 01", host_gnt_o);
        else passed++;
        for (int k = 1; k <= TO; k++) begin
            next_cycle();
            host_req_i     = 2'b00;
            device_rdata_i = 32'hBAD0_0000 + 32'(k);
            #1;
            total++;
            if (k < TO) begin
                if (host_rvalid_o !== 2'b00 || busy_o !== 1'b1)
                    $display("FAIL to_wait%0d got rv=%b busy=%b exp 00 1", k, host_rvalid_o, busy_o);
                else passed++;
            end else begin
                if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b01 || host_rdata_o !== 32'h0)
                    $display("FAIL to_err got rv=%b err=%b rdata=%h exp 01 01 0",
                             host_rvalid_o, host_err_o, host_rdata_o);
                else passed++;
            end
        end
        next_cycle();
        host_req_i = 2'b10;
        #1;
        total++;
        if (host_gnt_o !== 2'b10 || busy_o !== 1'b1 || host_rvalid_o !== 2'b00)
            $display("FAIL to_next got gnt=%b busy=%b rv=%b exp 10 1 00", host_gnt_o, busy_o, host_rvalid_o);
        else passed++;
        // Second transaction answers exactly in the timeout cycle.
        for (int k = 1; k <= TO; k++) begin
            next_cycle();
            host_req_i      = 2'b00;
            device_rvalid_i = (k == TO);
            device_rdata_i  = 32'h5EED_0016;
        end
        #1;
        total++;
        if (host_rvalid_o !== 2'b10 || host_err_o !== 2'b00 || host_rdata_o !== 32'h5EED_0016)
            $display("FAIL to_race got rv=%b err=%b rdata=%h exp 10 00 5eed0016",
                     host_rvalid_o, host_err_o, host_rdata_o);
        else passed++;
        next_cycle();
        device_rvalid_i = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            device_rvalid_i = 1'b1;
            device_rdata_i  = 32'h1234_0000 + 32'(k);
            #1;
            total++;
            if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00 || host_rdata_o !== 32'h0 || busy_o !== 1'b0)
                $display("FAIL spurious%0d got rv=%b err=%b rdata=%h busy=%b exp 00 00 0 0",
                         k, host_rvalid_o, host_err_o, host_rdata_o, busy_o);
            else passed++;
            next_cycle();
        end
        device_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        host_req_i = 2'b01;
        next_cycle();
        host_req_i = 2'b11;
        #1;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({host_gnt_o, host_rvalid_o, host_err_o, device_req_o, busy_o, host_rdata_o} !== '0)
            $display("FAIL midwait_rst got gnt=%b rv=%b err=%b req=%b busy=%b rdata=%h exp all 0",
                     host_gnt_o, host_rvalid_o, host_err_o, device_req_o, busy_o, host_rdata_o);
        else passed++;
        next_cycle();
        device_rvalid_i = 1'b1;
        #1;
        total++;
        if (host_rvalid_o !== 2'b00)
            $display("FAIL midwait_noresp got rv=%b exp 00", host_rvalid_o);
        else passed++;
        device_rvalid_i = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        #1;
        total++;
        if (host_gnt_o !== 2'b01)
            $display("FAIL midwait_ptr got gnt=%b exp 01", host_gnt_o);
        else passed++;
        next_cycle();
        host_req_i      = 2'b00;
        device_rvalid_i = 1'b1;
        next_cycle();
        device_rvalid_i = 1'b0;
    endtask

    // Randomized run against a transaction-level model: each host either has
    // a pending request or not, the device answers after a chosen latency,
    // and the arbiter must serve pending hosts in rotating order.
    task automatic test_random();
        bit            pend [NH];
        int            ptr, owner, waited, lat, w;
        bit            in_flight, any, to_hit;
        logic [NH-1:0] e_gnt, e_rv, e_err;
        logic [31:0]   e_rdata;
        logic          e_req, e_busy;
        do_reset();
        for (int k = 0; k < NH; k++) pend[k] = 1'b0;
        ptr = 0; owner = 0; waited = 0; lat = 0; in_flight = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            next_cycle();
            for (int k = 0; k < NH; k++) begin
                if (!pend[k] && ($urandom % 3 == 0)) begin
                    pend[k]    = 1'b1;
                    h_addr[k]  = $urandom;
                    h_we[k]    = 1'($urandom);
                    h_be[k]    = 4'($urandom);
                    h_wdata[k] = $urandom;
                end
                host_req_i[k] = pend[k];
            end
            if (in_flight) begin
                waited++;
                device_rvalid_i = (waited == lat);
            end else begin
                device_rvalid_i = ($urandom % 4 == 0);
            end
            device_rdata_i = $urandom;
            #1;
            any = 1'b0;
            w   = 0;
            for (int k = NH - 1; k >= 0; k--) begin
                if (pend[(ptr + k) % NH]) begin
                    any = 1'b1;
                    w   = (ptr + k) % NH;
                end
            end
            e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0;
            to_hit = 1'b0;
            if (!in_flight) begin
                e_req  = any;
                e_busy = any;
                if (any) e_gnt[w] = 1'b1;
            end else begin
                e_req  = 1'b0;
                e_busy = 1'b1;
                to_hit = !device_rvalid_i && (waited == TO);
                if (device_rvalid_i || to_hit) begin
                    e_rv[owner]  = 1'b1;
                    e_err[owner] = to_hit;
                    e_rdata      = device_rvalid_i ? device_rdata_i : 32'h0;
                end
            end
            total++;
            if (host_gnt_o !== e_gnt || device_req_o !== e_req || busy_o !== e_busy)
                $display("FAIL rnd_ctrl cyc%0d got gnt=%b req=%b busy=%b exp gnt=%b req=%b busy=%b",
                         cyc, host_gnt_o, device_req_o, busy_o, e_gnt, e_req, e_busy);
            else passed++;
            total++;
            if (host_rvalid_o !== e_rv || host_err_o !== e_err || host_rdata_o !== e_rdata)
                $display("FAIL rnd_resp cyc%0d got rv=%b err=%b rdata=%h exp rv=%b err=%b rdata=%h",
                         cyc, host_rvalid_o, host_err_o, host_rdata_o, e_rv, e_err, e_rdata);
            else passed++;
            if (e_req) begin
                total++;
                if (device_addr_o !== h_addr[w] || device_we_o !== h_we[w] ||
                    device_be_o !== h_be[w] || device_wdata_o !== h_wdata[w])
                    $display("FAIL rnd_fields cyc%0d got addr=%h we=%b be=%b wdata=%h exp addr=%h we=%b be=%b wdata=%h",
                             cyc, device_addr_o, device_we_o, device_be_o, device_wdata_o,
                             h_addr[w], h_we[w], h_be[w], h_wdata[w]);
                else passed++;
            end
            if (!in_flight && any) begin
                owner     = w;
                pend[w]   = 1'b0;
                ptr       = (w + 1) % NH;
                in_flight = 1'b1;
                waited    = 0;
                case ($urandom % 8)
                    0:       lat = TO;
                    1:       lat = TO + 20;
                    default: lat = 1 + int'($urandom % 3);
                endcase
            end else if (in_flight && (device_rvalid_i || to_hit)) begin
                in_flight = 1'b0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_write_be();
        test_timeout();
        test_spurious();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
